// File: rtl/gpu_bg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_bg_pkg
//  Purpose  : Shared constants and types for the GPU background-block
//             sequencer: bus widths, FSM state encoding and block-step codes.
//  Revision : 1.0 - initial release
// ============================================================================
package gpu_bg_pkg;

  // {scrY[8:0], scrX[9:4]} block address
  localparam int ADR_W = 15;
  // 16 pixels x 16 bit
  localparam int BLK_W = 256;
  // one bit per pixel
  localparam int MSK_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SAVE      = 3'd1,
    LOAD      = 3'd2,
    LOAD_WAIT = 3'd3,
    IMPORT    = 3'd4,
    DONE      = 3'd5
  } state_t;

  // Any other step code (1x) means a previous block exists and must be saved.
  localparam logic [1:0] STEP_NONE  = 2'b00;
  localparam logic [1:0] STEP_FIRST = 2'b01;

endpackage
`default_nettype wire

// File: rtl/gpu_bg_block_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_bg_block_sequencer
//  Purpose  : Sequences BG block traffic for the pixel backend: write-back of
//             the finished block, fetch of the next one, one-cycle import and
//             one-cycle new-block reset. Owns the only BG memory port.
//  Ports    : clk / i_rst (async, active-high)
//             backend in : i_blockStep, i_writePixelOnNewBlock, i_noblend,
//                          i_missTC, i_loadAdr, i_saveAdr, i_bgBlock, i_bgMask
//             backend out: o_pausePipeline, o_resetPixelOnNewBlock,
//                          o_importBGBlock, o_importedBGBlock
//             memory     : o_memReq, o_memWrite, o_memAdr, o_memWrData,
//                          o_memWrMask, i_memAck, i_memRdValid, i_memRdData
//             status     : o_protoErr (sticky)
//  Options  : GPU_BG_SKIP_EMPTY_SAVE_EN - skip the write-back of a block whose
//             written-pixel mask is all zero.
//  Revision : 1.0 - initial release
// ============================================================================
module gpu_bg_block_sequencer #(
  parameter int ADR_W = gpu_bg_pkg::ADR_W,
  parameter int BLK_W = gpu_bg_pkg::BLK_W,
  parameter int MSK_W = gpu_bg_pkg::MSK_W
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [1:0]       i_blockStep,
  input  logic             i_writePixelOnNewBlock,
  input  logic             i_noblend,
  input  logic             i_missTC,
  input  logic [ADR_W-1:0] i_loadAdr,
  input  logic [ADR_W-1:0] i_saveAdr,
  input  logic [BLK_W-1:0] i_bgBlock,
  input  logic [MSK_W-1:0] i_bgMask,
  output logic             o_pausePipeline,
  output logic             o_resetPixelOnNewBlock,
  output logic             o_importBGBlock,
  output logic [BLK_W-1:0] o_importedBGBlock,
  output logic             o_memReq,
  output logic             o_memWrite,
  output logic [ADR_W-1:0] o_memAdr,
  output logic [BLK_W-1:0] o_memWrData,
  output logic [MSK_W-1:0] o_memWrMask,
  input  logic             i_memAck,
  input  logic             i_memRdValid,
  input  logic [BLK_W-1:0] i_memRdData,
  output logic             o_protoErr
);
  import gpu_bg_pkg::*;

  state_t             state_q, state_d;
  logic               noblend_q;
  logic [ADR_W-1:0]   loadAdr_q;
  logic [ADR_W-1:0]   saveAdr_q;
  logic [BLK_W-1:0]   blk_q;
  logic [MSK_W-1:0]   mask_q;
  logic [BLK_W-1:0]   imp_q;
  logic               protoErr_q;

  logic               w_stepLater;
  logic               w_doSave;
  logic               w_trigger;
  logic               w_capture;
  logic               w_err;

  // Step 1x: a previous block exists in the backend and must be written back.
  assign w_stepLater = (i_blockStep != STEP_NONE) && (i_blockStep != STEP_FIRST);

`ifdef GPU_BG_SKIP_EMPTY_SAVE_EN
  assign w_doSave = w_stepLater && (i_bgMask != '0);
`else
  assign w_doSave = w_stepLater;
`endif

  assign w_trigger = (state_q == IDLE) && i_writePixelOnNewBlock;

  // Read data is accepted in LOAD only together with the ack; otherwise in LOAD_WAIT.
  assign w_capture = i_memRdValid &&
                     (((state_q == LOAD) && i_memAck) || (state_q == LOAD_WAIT));

  assign w_err = (i_memRdValid && (state_q != LOAD) && (state_q != LOAD_WAIT)) ||
                 (i_memAck && !o_memReq);

  // Combinational so the pixel in the trigger cycle is already held back.
  assign o_pausePipeline   = (state_q != IDLE) || i_writePixelOnNewBlock || i_missTC;
  assign o_importedBGBlock = imp_q;
  assign o_protoErr        = protoErr_q;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      noblend_q  <= 1'b0;
      loadAdr_q  <= '0;
      saveAdr_q  <= '0;
      blk_q      <= '0;
      mask_q     <= '0;
      imp_q      <= '0;
      protoErr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_trigger) begin
        noblend_q <= i_noblend;
        loadAdr_q <= i_loadAdr;
        saveAdr_q <= i_saveAdr;
        blk_q     <= i_bgBlock;
        mask_q    <= i_bgMask;
      end
      if (w_capture) begin
        imp_q <= i_memRdData;
      end
      if (w_err) begin
        protoErr_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d                = state_q;
    o_memReq               = 1'b0;
    o_memWrite             = 1'b0;
    o_memAdr               = '0;
    o_memWrData            = '0;
    o_memWrMask            = '0;
    o_importBGBlock        = 1'b0;
    o_resetPixelOnNewBlock = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_writePixelOnNewBlock) begin
          if (w_doSave) begin
            state_d = SAVE;
          end else if (!i_noblend) begin
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      SAVE: begin
        o_memReq    = 1'b1;
        o_memWrite  = 1'b1;
        o_memAdr    = saveAdr_q;
        o_memWrData = blk_q;
        o_memWrMask = mask_q;
        if (i_memAck) begin
          state_d = noblend_q ? DONE : LOAD;
        end
      end
      LOAD: begin
        o_memReq = 1'b1;
        o_memAdr = loadAdr_q;
        if (i_memAck) begin
          state_d = i_memRdValid ? IMPORT : LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        if (i_memRdValid) begin
          state_d = IMPORT;
        end
      end
      IMPORT: begin
        o_importBGBlock = 1'b1;
        state_d         = DONE;
      end
      DONE: begin
        o_resetPixelOnNewBlock = 1'b1;
        state_d                = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
